// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - time-multiplexed 8-digit seven-segment scan driver
module seg7_scan_driver #(
  parameter int SCAN_DIV = 100000,
  parameter int GUARD    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] SW,
  input  logic [7:0]  blank_mask,
  input  logic [7:0]  dp_mask,
  input  logic        freeze,
  output logic [6:0]  Cnode,
  output logic        dp,
  output logic [7:0]  AN,
  output logic        frame_done
);

  localparam int PW = (SCAN_DIV < 2) ? 1 : $clog2(SCAN_DIV);
  localparam int GW = (GUARD < 1) ? 1 : $clog2(GUARD + 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [GW-1:0] GUARD_L  = GW'(GUARD);

  logic [PW-1:0] pre;
  logic [2:0]    idx;
  logic [GW-1:0] gc;
  logic [31:0]   snap;

  logic          tick;
  logic          frame_end;
  logic [2:0]    idx_n;
  logic [GW-1:0] gc_n;
  logic [31:0]   snap_n;
  logic [3:0]    nib_n;
  logic [7:0]    an_n;

  function automatic logic [6:0] hex_seg(input logic [3:0] v);
    case (v)
      4'h0: hex_seg = 7'h40;
      4'h1: hex_seg = 7'h79;
      4'h2: hex_seg = 7'h24;
      4'h3: hex_seg = 7'h30;
      4'h4: hex_seg = 7'h19;
      4'h5: hex_seg = 7'h12;
      4'h6: hex_seg = 7'h02;
      4'h7: hex_seg = 7'h78;
      4'h8: hex_seg = 7'h00;
      4'h9: hex_seg = 7'h10;
      4'hA: hex_seg = 7'h08;
      4'hB: hex_seg = 7'h03;
      4'hC: hex_seg = 7'h46;
      4'hD: hex_seg = 7'h21;
      4'hE: hex_seg = 7'h06;
      default: hex_seg = 7'h0E;
    endcase
  endfunction

  // Next-state values; outputs are derived from these so they reflect the post-update digit and guard.
  always_comb begin
    tick      = (pre == PRE_LAST);
    frame_end = tick && (idx == 3'd7);
    idx_n     = tick ? idx + 3'd1 : idx;
    if (tick)
      gc_n = GUARD_L;
    else if (gc != '0)
      gc_n = gc - GW'(1);
    else
      gc_n = '0;
    snap_n = (frame_end && !freeze) ? SW : snap;
    nib_n  = snap_n[{idx_n, 2'b00} +: 4];
    if (gc_n != '0 || blank_mask[idx_n])
      an_n = 8'hFF;
    else
      an_n = ~(8'h01 << idx_n);
  end

  // Scan state and registered pin outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre        <= '0;
      idx        <= '0;
      gc         <= GUARD_L;
      snap       <= '0;
      AN         <= 8'hFF;
      Cnode      <= 7'h7F;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      pre        <= tick ? '0 : pre + PW'(1);
      idx        <= idx_n;
      gc         <= gc_n;
      snap       <= snap_n;
      AN         <= an_n;
      Cnode      <= hex_seg(nib_n);
      dp         <= ~dp_mask[idx_n];
      frame_done <= frame_end;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - scoreboard bench for seg7_scan_driver (GUARD=1 and GUARD=0)
module tb_seg7_scan_driver;

  localparam int SD = 4;
  localparam int FRAME = 8 * SD;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] sw;
  logic [7:0]  bm, dm;
  logic        fz;

  logic [6:0]  c1, c0;
  logic        d1, d0;
  logic [7:0]  an1, an0;
  logic        fd1, fd0;

  always #5 clk = ~clk;

  seg7_scan_driver #(.SCAN_DIV(SD), .GUARD(1)) dut_g1 (
    .clk(clk), .rst(rst), .SW(sw), .blank_mask(bm), .dp_mask(dm), .freeze(fz),
    .Cnode(c1), .dp(d1), .AN(an1), .frame_done(fd1)
  );

  seg7_scan_driver #(.SCAN_DIV(SD), .GUARD(0)) dut_g0 (
    .clk(clk), .rst(rst), .SW(sw), .blank_mask(bm), .dp_mask(dm), .freeze(fz),
    .Cnode(c0), .dp(d0), .AN(an0), .frame_done(fd0)
  );

  typedef struct {
    int         due;
    int         guard;
    logic [6:0] c;
    logic       d;
    logic [7:0] an;
    logic       fd;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // reference model state: edges since reset release and the snapshot word
  int          t = 0;
  logic [31:0] snap_m = 32'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int g, input logic [7:0] act, input logic [7:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s guard=%0d cyc=%0d got=%h want=%h", nm, g, cyc, act, want);
    end
  endtask

  // monitor: compare whatever the DUTs present against due scoreboard entries
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due == cyc) begin
      exp_t e;
      logic [6:0] ac;
      logic       ad, af;
      logic [7:0] aa;
      e = q.pop_front();
      if (e.guard == 1) begin ac = c1; ad = d1; aa = an1; af = fd1; end
      else              begin ac = c0; ad = d0; aa = an0; af = fd0; end
      chk("cnode", e.guard, {1'b0, ac}, {1'b0, e.c});
      chk("dp", e.guard, {7'b0, ad}, {7'b0, e.d});
      chk("an", e.guard, aa, e.an);
      chk("frame_done", e.guard, {7'b0, af}, {7'b0, e.fd});
      chk("an_onehot", e.guard, 8'($countones(~aa) <= 1), 8'd1);
    end
  end

  // apply inputs for the next edge, advance the model and queue the expected outputs
  task automatic drive(input logic r, input logic [31:0] s, input logic [7:0] b,
                       input logic [7:0] m, input logic f);
    exp_t e;
    int   di, sl, gcv;
    rst = r; sw = s; bm = b; dm = m; fz = f;
    if (r) begin
      t = 0;
      snap_m = 32'h0;
    end else begin
      t++;
      if (t % FRAME == 0 && !f) snap_m = s;
    end
    for (int g = 1; g >= 0; g--) begin
      e.due   = cyc + 1;
      e.guard = g;
      if (r) begin
        e.c = 7'h7F; e.d = 1'b1; e.an = 8'hFF; e.fd = 1'b0;
      end else begin
        di  = (t / SD) % 8;
        sl  = t % SD;
        gcv = (g - sl > 0) ? g - sl : 0;
        e.c  = seg_tab[(snap_m >> (4 * di)) & 32'hF];
        e.d  = ~m[di];
        e.an = (gcv != 0 || b[di]) ? 8'hFF : ~(8'h01 << di);
        e.fd = (t % FRAME == 0);
      end
      q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset then the first two frames
    for (int i = 0; i < 3; i++) drive(1'b1, 32'h76543210, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 2 * FRAME; i++) drive(1'b0, 32'h76543210, 8'h00, 8'h00, 1'b0);
    // mid-frame word change must not tear
    for (int i = 0; i < 14; i++) drive(1'b0, 32'h76543210, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 50; i++) drive(1'b0, 32'hFEDCBA98, 8'h00, 8'h00, 1'b0);
    // freeze across a boundary
    for (int i = 0; i < 40; i++) drive(1'b0, $urandom, 8'h00, 8'h00, 1'b1);
    for (int i = 0; i < 40; i++) drive(1'b0, 32'h13579BDF, 8'h00, 8'h00, 1'b0);
    // blanking and decimal points
    for (int i = 0; i < 40; i++) drive(1'b0, 32'h13579BDF, 8'h0F, 8'h81, 1'b0);
    // reset during slot 5
    for (int i = 0; i < 40 && ((t / SD) % 8) != 5; i++) drive(1'b0, 32'hCAFEF00D, 8'h00, 8'h00, 1'b0);
    drive(1'b0, 32'hCAFEF00D, 8'h00, 8'h00, 1'b0);
    drive(1'b1, 32'hCAFEF00D, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 70; i++) drive(1'b0, 32'hCAFEF00D, 8'h00, 8'h00, 1'b0);
    // randomized traffic
    for (int i = 0; i < 700; i++)
      drive(($urandom_range(0, 199) == 0), $urandom, 8'($urandom), 8'($urandom),
            ($urandom_range(0, 3) == 0));
    drive(1'b0, 32'h0, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", 0, 8'(q.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
